// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter
// Round-robin arbiter that shares one single-port data RAM between
// NUM_CORES load/store units. Each core issues one word access per
// req/ack handshake. A core may keep the grant across back-to-back
// accesses by holding lock. An idle lock is released after LOCK_TIMEOUT
// cycles, and a LOCK_TIMEOUT of 0 disables that release.
// The RAM is byte-addressable and big-endian within a word: the byte at
// addr lands in bits [31:24]. Reads are combinational, and writes land
// on the clock edge that ends the ACCESS cycle.

module mem_data_arbiter #(
  parameter int NUM_CORES    = 2,
  parameter int MEM_BYTES    = 12,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CORES-1:0]   req,
  input  logic [NUM_CORES-1:0]   we,
  input  logic [NUM_CORES-1:0]   lock,
  input  logic [32*NUM_CORES-1:0] addr,
  input  logic [32*NUM_CORES-1:0] wdata,
  output logic [NUM_CORES-1:0]   ack,
  output logic                   err,
  output logic [31:0]            rdata,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic                   mem_we,
  input  logic [31:0]            mem_rdata
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  // Highest byte address at which a full word still fits in the RAM
  localparam logic [31:0]      ADDR_LAST = 32'(MEM_BYTES - 4);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CORES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  =
    CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_next;
  logic [IDX_W-1:0] owner_succ;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_next;

  logic [NUM_CORES-1:0] owner_onehot;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic                 sel_we;
  logic                 sel_req;
  logic                 sel_lock;
  logic                 in_range;

  // Round-robin pick: the first requester at or above ptr, otherwise the lowest requester (wrap-around)
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (!found && req[j] && (IDX_W'(j) >= ptr)) begin
        winner = IDX_W'(j);
        found  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_CORES; j++) begin
      if (!found && req[j]) begin
        winner = IDX_W'(j);
        found  = 1'b1;
      end
    end
  end

  // Mux the current owner's request fields out of the packed per-core buses
  always_comb begin
    owner_onehot = '0;
    sel_addr     = '0;
    sel_wdata    = '0;
    sel_we       = 1'b0;
    sel_req      = 1'b0;
    sel_lock     = 1'b0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (owner == IDX_W'(j)) begin
        owner_onehot[j] = 1'b1;
        sel_addr        = addr[32*j +: 32];
        sel_wdata       = wdata[32*j +: 32];
        sel_we          = we[j];
        sel_req         = req[j];
        sel_lock        = lock[j];
      end
    end
  end

  // Pointer value that moves fairness past the current owner, wrapping at NUM_CORES
  always_comb begin
    owner_succ = (owner == IDX_LAST) ? '0 : owner + 1'b1;
    in_range   = (sel_addr <= ADDR_LAST);
  end

  // Next-state logic for grant, release and lock-timeout handling
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    owner_next    = owner;
    hold_cnt_next = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (found) begin
          owner_next = winner;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (sel_lock) begin
          state_next    = ST_HOLD;
          hold_cnt_next = '0;
        end else begin
          state_next = ST_IDLE;
          ptr_next   = owner_succ;
        end
      end
      ST_HOLD: begin
        if (!sel_lock) begin
          state_next = ST_IDLE;
          ptr_next   = owner_succ;
        end else if (sel_req) begin
          state_next = ST_ACCESS;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
          if ((LOCK_TIMEOUT != 0) && (hold_cnt == CNT_LAST)) begin
            state_next = ST_IDLE;
            ptr_next   = owner_succ;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Drive the RAM only during ACCESS, and never in a reset cycle, so an aborted access cannot write
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if ((state == ST_ACCESS) && !reset) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      mem_we    = sel_we & in_range;
    end
  end

  // State, fairness pointer, owner and hold-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      owner    <= owner_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // Registered response: one-cycle ack to the owner, with err and load data captured at the end of ACCESS
  always_ff @(posedge clk) begin
    if (reset) begin
      ack   <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      if (state == ST_ACCESS) begin
        ack   <= owner_onehot;
        err   <= !in_range;
        rdata <= in_range ? mem_rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb_mem_data_arbiter
// Directed bench for mem_data_arbiter with NUM_CORES=2, MEM_BYTES=12 and
// LOCK_TIMEOUT=16. It drives a small big-endian byte RAM alongside the
// arbiter and checks values cycle by cycle against hand-computed vectors.

module tb_mem_data_arbiter;

  localparam int NUM_CORES    = 2;
  localparam int MEM_BYTES    = 12;
  localparam int LOCK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  lock;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [7:0] ram [MEM_BYTES] = '{8'h00, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00,
                                  8'h11, 8'h22, 8'h33, 8'h44};

  logic [1:0] rrAck [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                             2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};

  int checkCount = 0;
  int errorCount = 0;

  mem_data_arbiter #(
    .NUM_CORES    (NUM_CORES),
    .MEM_BYTES    (MEM_BYTES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // Combinational RAM read, big-endian within the word
  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 32'(MEM_BYTES - 4)) begin
      mem_rdata = {ram[mem_addr[3:0]], ram[mem_addr[3:0] + 4'd1],
                   ram[mem_addr[3:0] + 4'd2], ram[mem_addr[3:0] + 4'd3]};
    end
  end

  // RAM write on the rising edge whenever the arbiter asserts mem_we
  always @(posedge clk) begin
    if (mem_we && (mem_addr <= 32'(MEM_BYTES - 4))) begin
      ram[mem_addr[3:0]]        <= mem_wdata[31:24];
      ram[mem_addr[3:0] + 4'd1] <= mem_wdata[23:16];
      ram[mem_addr[3:0] + 4'd2] <= mem_wdata[15:8];
      ram[mem_addr[3:0] + 4'd3] <= mem_wdata[7:0];
    end
  end

  // Stops a runaway simulation
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] ramWord(input logic [3:0] a);
    return {ram[a], ram[a + 4'd1], ram[a + 4'd2], ram[a + 4'd3]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int core, input logic r, input logic w,
                               input logic l, input logic [31:0] a,
                               input logic [31:0] d);
    req[core]            = r;
    we[core]             = w;
    lock[core]           = l;
    addr[32*core +: 32]  = a;
    wdata[32*core +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic [1:0] expAck,
                            input logic expWe);
    checkOutput({tag, "_ack"}, {30'b0, ack}, {30'b0, expAck});
    checkOutput({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, expWe});
  endtask

  // Directed test sequence
  initial begin
    reset = 1'b1;
    req   = '0;
    we    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;
    tick();
    tick();
    checkOutput("reset_ack", {30'b0, ack}, 32'h0);
    checkOutput("reset_err", {31'b0, err}, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_mem_we", {31'b0, mem_we}, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // Single load from core 0
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd8, 32'h0);
    tick();
    checkCycle("load_access", 2'b00, 1'b0);
    checkOutput("load_mem_addr", mem_addr, 32'd8);
    tick();
    checkCycle("load_done", 2'b01, 1'b0);
    checkOutput("load_rdata", rdata, 32'h11223344);
    checkOutput("load_err", {31'b0, err}, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkCycle("load_idle", 2'b00, 1'b0);

    // Single store from core 1, then read back by core 0
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'd4, 32'h000A0B0C);
    tick();
    checkCycle("store_access", 2'b00, 1'b1);
    checkOutput("store_mem_addr", mem_addr, 32'd4);
    checkOutput("store_mem_wdata", mem_wdata, 32'h000A0B0C);
    tick();
    checkCycle("store_done", 2'b10, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("store_ram", ramWord(4'd4), 32'h000A0B0C);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    tick();
    tick();
    checkOutput("readback_ack", {30'b0, ack}, 32'h1);
    checkOutput("readback_rdata", rdata, 32'h000A0B0C);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Round-robin with both cores requesting continuously from ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd8, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    for (int k = 0; k < 12; k++) begin
      tick();
      checkOutput($sformatf("rr_ack_%0d", k), {30'b0, ack}, {30'b0, rrAck[k]});
      if (rrAck[k] == 2'b01) checkOutput($sformatf("rr_rdata_%0d", k), rdata, 32'h11223344);
      if (rrAck[k] == 2'b10) checkOutput($sformatf("rr_rdata_%0d", k), rdata, 32'h000A0B0C);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Locked read-modify-write by core 0 while core 1 waits
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'd8, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    tick();
    checkCycle("lock_l1", 2'b00, 1'b0);
    checkOutput("lock_l1_mem_addr", mem_addr, 32'd8);
    tick();
    checkCycle("lock_l2", 2'b01, 1'b0);
    checkOutput("lock_l2_rdata", rdata, 32'h11223344);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'd8, 32'h11223345);
    tick();
    checkCycle("lock_l3", 2'b00, 1'b0);
    tick();
    checkCycle("lock_l4", 2'b00, 1'b1);
    checkOutput("lock_l4_mem_wdata", mem_wdata, 32'h11223345);
    tick();
    checkCycle("lock_l5", 2'b01, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkCycle("lock_l6", 2'b00, 1'b0);
    tick();
    checkCycle("lock_l7", 2'b00, 1'b0);
    checkOutput("lock_l7_mem_addr", mem_addr, 32'd4);
    tick();
    checkCycle("lock_l8", 2'b10, 1'b0);
    checkOutput("lock_l8_rdata", rdata, 32'h000A0B0C);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("lock_final_word", ramWord(4'd8), 32'h11223345);

    // Out-of-range store at address 9
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'd9, 32'hDEADBEEF);
    tick();
    checkCycle("oor_access", 2'b00, 1'b0);
    checkOutput("oor_mem_addr", mem_addr, 32'd9);
    tick();
    checkCycle("oor_done", 2'b01, 1'b0);
    checkOutput("oor_err", {31'b0, err}, 32'h1);
    checkOutput("oor_rdata", rdata, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("oor_err_clear", {31'b0, err}, 32'h0);
    checkOutput("oor_ram0", ramWord(4'd0), 32'h00000000);
    checkOutput("oor_ram4", ramWord(4'd4), 32'h000A0B0C);
    checkOutput("oor_ram8", ramWord(4'd8), 32'h11223345);

    // Lock timeout: core 0 holds lock idle and core 1 is granted after the forced release
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'd8, 32'h0);
    tick();
    tick();
    checkOutput("to_ack0", {30'b0, ack}, 32'h1);
    checkOutput("to_rdata0", rdata, 32'h11223345);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'd8, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    for (int k = 3; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("to_wait_%0d", k), {30'b0, ack}, 32'h0);
    end
    tick();
    checkOutput("to_ack1", {30'b0, ack}, 32'h2);
    checkOutput("to_rdata1", rdata, 32'h000A0B0C);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Reset during ACCESS aborts the store and clears ptr
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd8, 32'h0);
    tick();
    tick();
    checkOutput("rst_pre_ack", {30'b0, ack}, 32'h1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'd0, 32'hCAFEF00D);
    tick();
    checkOutput("rst_access_we", {31'b0, mem_we}, 32'h1);
    reset = 1'b1;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("rst_gate_we", {31'b0, mem_we}, 32'h0);
    checkOutput("rst_gate_addr", mem_addr, 32'h0);
    checkOutput("rst_gate_wdata", mem_wdata, 32'h0);
    tick();
    checkOutput("rst_ack", {30'b0, ack}, 32'h0);
    checkOutput("rst_err", {31'b0, err}, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    checkOutput("rst_ram0", ramWord(4'd0), 32'h00000000);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd8, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    tick();
    checkOutput("rst_post_access", {30'b0, ack}, 32'h0);
    tick();
    checkOutput("rst_post_ack", {30'b0, ack}, 32'h1);
    checkOutput("rst_post_rdata", rdata, 32'h11223345);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
